// File: rtl/quiz_round_controller.sv
// quiz_round_controller: 4-player buzzer quiz FSM (IDLE/ARMED/ANSWER/DONE) with edge-detected buzzers, round-robin tie-break, answer-window timer, per-question lockout and saturating 4-bit scores; ports clk/rst(async high), buzzer[3:0], host_start/correct/wrong pulses in, armed/winner_valid/winner_id/lockout/timeout/scores out; define FALSE_START_LOCKOUT_EN to lock out players who press before the question opens
module quiz_round_controller #(
  parameter int N_PLAYERS = 4,
  parameter int ANSWER_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  buzzer,
  input  logic        host_start,
  input  logic        host_correct,
  input  logic        host_wrong,
  output logic        armed,
  output logic        winner_valid,
  output logic [1:0]  winner_id,
  output logic [3:0]  lockout,
  output logic        timeout,
  output logic [15:0] scores
);
  typedef enum logic [1:0] {IDLE, ARMED, ANSWER, DONE} state_t;
  localparam logic [3:0] ALL_LOCKED = 4'((1 << N_PLAYERS) - 1);
  state_t state, state_n;
  logic [3:0] buz_q, buz_d, press, cand, lock_set, cur_score;
  logic [1:0] rr_ptr, win, idx;
  logic [15:0] timer;
  logic found, do_start, do_capture, do_correct, do_wrong, expire;
`ifdef FALSE_START_LOCKOUT_EN
  logic [3:0] pending;
`endif
  assign press = buz_q & ~buz_d;
  assign cand = press & ~lockout;
  assign lock_set = lockout | (4'b0001 << winner_id);
  assign cur_score = scores[{winner_id, 2'b00} +: 4];
  assign armed = state == ARMED;
  assign winner_valid = state == ANSWER;
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    idx = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && cand[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    do_start = 1'b0;
    do_capture = 1'b0;
    do_correct = 1'b0;
    do_wrong = 1'b0;
    expire = 1'b0;
    case (state)
      IDLE, DONE: begin
        do_start = host_start;
        state_n = host_start ? ARMED : state;
      end
      ARMED: begin
        do_capture = found;
        state_n = found ? ANSWER : ARMED;
      end
      ANSWER: begin
        do_correct = host_correct;
        do_wrong = !host_correct && host_wrong;
        expire = !host_correct && !host_wrong && timer == 16'd0;
        state_n = do_correct ? DONE :
                  (do_wrong || expire) ? ((lock_set == ALL_LOCKED) ? DONE : ARMED) : ANSWER;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buz_q <= '0;
      buz_d <= '0;
      winner_id <= '0;
      lockout <= '0;
      timeout <= 1'b0;
      scores <= '0;
      timer <= '0;
      rr_ptr <= '0;
`ifdef FALSE_START_LOCKOUT_EN
      pending <= '0;
`endif
    end else begin
      buz_q <= buzzer;
      buz_d <= buz_q;
      timeout <= expire;
`ifdef FALSE_START_LOCKOUT_EN
      if (do_start) begin
        lockout <= pending;
        pending <= '0;
      end else if (state == IDLE || state == DONE) begin
        pending <= pending | press;
      end
`else
      if (do_start) lockout <= '0;
`endif
      if (do_capture) begin
        winner_id <= win;
        rr_ptr <= win + 2'd1;
        timer <= 16'(ANSWER_CYCLES - 1);
      end else if (state == ANSWER && timer != 16'd0) begin
        timer <= timer - 16'd1;
      end
      if (do_wrong || expire) lockout <= lock_set;
      if (do_correct && cur_score != 4'hF) scores[{winner_id, 2'b00} +: 4] <= cur_score + 4'd1;
    end
  end
endmodule

// File: tb/tb_quiz_round_controller.sv
// tb_quiz_round_controller: scoreboard bench for quiz_round_controller
module tb_quiz_round_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] buzzer = '0;
  logic host_start = 1'b0, host_correct = 1'b0, host_wrong = 1'b0;
  logic armed, winner_valid, timeout;
  logic [1:0] winner_id;
  logic [3:0] lockout;
  logic [15:0] scores;
  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  logic prev_wv = 1'b0;
`ifdef FALSE_START_LOCKOUT_EN
  localparam logic [3:0] EXP_FS = 4'b1000;
`else
  localparam logic [3:0] EXP_FS = 4'b0000;
`endif
  quiz_round_controller #(.N_PLAYERS(4), .ANSWER_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .buzzer(buzzer), .host_start(host_start),
    .host_correct(host_correct), .host_wrong(host_wrong), .armed(armed),
    .winner_valid(winner_valid), .winner_id(winner_id), .lockout(lockout),
    .timeout(timeout), .scores(scores)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (winner_valid === 1'b1 && prev_wv !== 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL capture_unexpected: got winner %0d, required no capture", winner_id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (winner_id !== e) begin
          n_fail++;
          $display("FAIL capture_winner: got %0d, required %0d", winner_id, e);
        end
      end
    end
    prev_wv = winner_valid;
  end
  task automatic do_reset;
    rst = 1'b1;
    buzzer = '0;
    host_start = 1'b0;
    host_correct = 1'b0;
    host_wrong = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic start_q;
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
  endtask
  task automatic judge(input logic c, input logic w);
    host_correct = c;
    host_wrong = w;
    @(negedge clk);
    host_correct = 1'b0;
    host_wrong = 1'b0;
  endtask
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (winner_valid === 1'b1);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({armed, winner_valid, winner_id, lockout, timeout} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 000000000", {armed, winner_valid, winner_id, lockout, timeout});
    end
    n_checks++;
    if (scores !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_scores: got %h, required 0000", scores);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    do_reset();
    start_q();
    n_checks++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b, required 1", armed); end
    buzzer = 4'b0010;
    exp_q.push_back(2'd1);
    @(negedge clk);
    n_checks++;
    if (winner_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b, required 0", winner_valid); end
    @(negedge clk);
    n_checks++;
    if (winner_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b, required 1", winner_valid); end
    buzzer = '0;
    start_q();
    n_checks++;
    if ({winner_valid, armed} !== 2'b10) begin n_fail++; $display("FAIL basic_start_ignored: got %b, required 10", {winner_valid, armed}); end
    judge(1'b1, 1'b0);
    n_checks++;
    if (scores !== 16'h0010) begin n_fail++; $display("FAIL basic_score: got %h, required 0010", scores); end
    n_checks++;
    if ({winner_valid, armed} !== 2'b00) begin n_fail++; $display("FAIL basic_done: got %b, required 00", {winner_valid, armed}); end
  endtask
  task automatic test_tie;
    bit ok;
    do_reset();
    start_q();
    buzzer = 4'b1001;
    exp_q.push_back(2'd0);
    wait_valid(4, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tie_first_valid: got 0, required 1"); end
    buzzer = '0;
    judge(1'b1, 1'b0);
    start_q();
    buzzer = 4'b1001;
    exp_q.push_back(2'd3);
    wait_valid(4, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tie_second_valid: got 0, required 1"); end
    buzzer = '0;
    judge(1'b1, 1'b1);
    n_checks++;
    if (scores !== 16'h1001) begin n_fail++; $display("FAIL tie_scores: got %h, required 1001", scores); end
    n_checks++;
    if (lockout !== 4'b0000) begin n_fail++; $display("FAIL precedence_lockout: got %b, required 0000", lockout); end
  endtask
  task automatic test_timeout;
    bit ok;
    int cnt;
    do_reset();
    start_q();
    buzzer = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(4, ok);
    buzzer = '0;
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 1100) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (!ok || cnt != 1000) begin n_fail++; $display("FAIL timeout_cycles: got %0d, required 1000", cnt); end
    n_checks++;
    if ({armed, lockout} !== 5'b1_0100) begin n_fail++; $display("FAIL timeout_lockout: got %b, required 10100", {armed, lockout}); end
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b, required 0", timeout); end
    buzzer = 4'b0100;
    repeat (3) @(negedge clk);
    n_checks++;
    if (winner_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_locked_press: got %b, required 0", winner_valid); end
    buzzer = '0;
    @(negedge clk);
    buzzer = 4'b0010;
    exp_q.push_back(2'd1);
    wait_valid(4, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_rebuzz: got 0, required 1"); end
    buzzer = '0;
    judge(1'b0, 1'b1);
  endtask
  task automatic test_all_wrong;
    bit ok;
    do_reset();
    start_q();
    for (int p = 0; p < 4; p++) begin
      buzzer = 4'(1 << p);
      exp_q.push_back(2'(p));
      wait_valid(4, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wrong_valid_p%0d: got 0, required 1", p); end
      buzzer = '0;
      judge(1'b0, 1'b1);
    end
    n_checks++;
    if ({armed, winner_valid, lockout} !== 6'b00_1111) begin
      n_fail++;
      $display("FAIL wrong_all_locked: got %b, required 001111", {armed, winner_valid, lockout});
    end
    start_q();
    n_checks++;
    if ({armed, lockout} !== 5'b1_0000) begin n_fail++; $display("FAIL wrong_restart: got %b, required 10000", {armed, lockout}); end
  endtask
  task automatic test_saturate;
    bit ok;
    do_reset();
    for (int r = 0; r < 17; r++) begin
      start_q();
      buzzer = 4'b0001;
      exp_q.push_back(2'd0);
      wait_valid(4, ok);
      buzzer = '0;
      judge(1'b1, 1'b0);
    end
    n_checks++;
    if (scores !== 16'h000F) begin n_fail++; $display("FAIL saturate: got %h, required 000f", scores); end
  endtask
  task automatic test_false_start;
    do_reset();
    buzzer = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    buzzer = '0;
    @(negedge clk);
    start_q();
    n_checks++;
    if (lockout !== EXP_FS) begin n_fail++; $display("FAIL false_start: got %b, required %b", lockout, EXP_FS); end
  endtask
  task automatic test_async_reset;
    bit ok;
    do_reset();
    start_q();
    buzzer = 4'b0010;
    exp_q.push_back(2'd1);
    wait_valid(4, ok);
    buzzer = '0;
    judge(1'b1, 1'b0);
    start_q();
    buzzer = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(4, ok);
    buzzer = '0;
    n_checks++;
    if (!ok || scores !== 16'h0010) begin n_fail++; $display("FAIL async_setup: got %b/%h, required 1/0010", ok, scores); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({armed, winner_valid, winner_id, lockout, timeout, scores} !== 25'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required 0", {armed, winner_valid, winner_id, lockout, timeout, scores});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_timeout();
    test_all_wrong();
    test_saturate();
    test_false_start();
    test_async_reset();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
